// File: rtl/pc_counter_pkg.sv
// Shared constants and helpers for the program-counter stage built from
// 74xx161-style 4-bit slices.
package pc_counter_pkg;

    localparam int PC_SLICE_BITS = 4;
    localparam logic [63:0] PC_DEFAULT_RESET_VALUE = 64'h0;

    // A zero-width request still yields one slice so declarations stay legal
    // while the top-level width check reports the real error.
    function automatic int pcSliceCount(input int width);
        int n;
        n = width / PC_SLICE_BITS;
        if (n < 1) begin
            n = 1;
        end
        return n;
    endfunction

endpackage

// File: rtl/counter_161.sv
// 74xx161-style synchronous 4-bit counter slice: async clear (active low),
// synchronous parallel load (active low), CEP/CET count enables, ripple TC.
import pc_counter_pkg::*;

module counter_161 #(
    parameter logic [PC_SLICE_BITS-1:0] RESET_NIBBLE = '0
) (
    input  logic                     i_clk,
    input  logic                     i_mrn,
    input  logic                     i_cep,
    input  logic                     i_cet,
    input  logic                     i_pen,
    input  logic [PC_SLICE_BITS-1:0] i_d,
    output logic [PC_SLICE_BITS-1:0] o_q,
    output logic                     o_tc
);

    logic [PC_SLICE_BITS-1:0] r_q;

    // Load outranks counting; both enables are needed to advance.
    always_ff @(posedge i_clk or negedge i_mrn) begin
        if (!i_mrn) begin
            r_q <= RESET_NIBBLE;
        end else if (!i_pen) begin
            r_q <= i_d;
        end else if (i_cep && i_cet) begin
            r_q <= r_q + 1'b1;
        end
    end

    assign o_q  = r_q;
    assign o_tc = (&r_q) & i_cet;

endmodule

// File: rtl/pc_counter.sv
// Program counter built from cascaded counter_161 slices, with a registered
// bus output enable and a sticky wrap-around diagnostic flag.
import pc_counter_pkg::*;

module pc_counter #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(PC_DEFAULT_RESET_VALUE)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             load,
    input  logic             oe,
    input  logic [WIDTH-1:0] bus_in,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] bus_out,
    output logic             bus_oe,
    output logic             tc,
    output logic             wrapped
);

    localparam int NSLICES = pcSliceCount(WIDTH);

    if ((WIDTH == 0) || ((WIDTH % PC_SLICE_BITS) != 0)) begin : g_badWidth
        $fatal(1, "pc_counter: WIDTH must be a non-zero multiple of 4");
    end

    logic [NSLICES-1:0]     w_sliceTc;
    logic [NSLICES-1:0]     w_sliceCet;
    logic [NSLICES*4-1:0]   w_q;
    logic                   w_mrn;
    logic                   w_wrapNext;
    logic                   r_busOe;
    logic                   r_wrapped;

    assign w_mrn = ~rst;

    // Ripple cascade: each slice only counts once every lower slice is at 0xF.
    for (genvar g = 0; g < NSLICES; g++) begin : g_slice
        if (g == 0) begin : g_first
            assign w_sliceCet[g] = 1'b1;
        end else begin : g_rest
            assign w_sliceCet[g] = w_sliceTc[g-1];
        end

        counter_161 #(
            .RESET_NIBBLE(RESET_VALUE[g*PC_SLICE_BITS +: PC_SLICE_BITS])
        ) u_slice (
            .i_clk (clk),
            .i_mrn (w_mrn),
            .i_cep (inc),
            .i_cet (w_sliceCet[g]),
            .i_pen (~load),
            .i_d   (bus_in[g*PC_SLICE_BITS +: PC_SLICE_BITS]),
            .o_q   (w_q[g*PC_SLICE_BITS +: PC_SLICE_BITS]),
            .o_tc  (w_sliceTc[g])
        );
    end

    assign q          = w_q[WIDTH-1:0];
    assign w_wrapNext = w_sliceTc[NSLICES-1] & inc & ~load;
    assign tc         = w_wrapNext & ~rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busOe   <= 1'b0;
            r_wrapped <= 1'b0;
        end else begin
            r_busOe <= oe;
            if (load) begin
                r_wrapped <= 1'b0;
            end else if (w_wrapNext) begin
                r_wrapped <= 1'b1;
            end
        end
    end

    assign bus_oe  = r_busOe;
    assign wrapped = r_wrapped;
    assign bus_out = r_busOe ? q : '0;

endmodule

// File: tb/tb_pc_counter.sv
// Directed self-checking bench for pc_counter (WIDTH=8, RESET_VALUE=0).
module tb_pc_counter;

    logic       clk;
    logic       rst;
    logic       inc;
    logic       load;
    logic       oe;
    logic [7:0] bus_in;
    logic [7:0] q;
    logic [7:0] bus_out;
    logic       bus_oe;
    logic       tc;
    logic       wrapped;

    int errors = 0;
    int checks = 0;

    pc_counter #(.WIDTH(8), .RESET_VALUE(8'h00)) dut (
        .clk     (clk),
        .rst     (rst),
        .inc     (inc),
        .load    (load),
        .oe      (oe),
        .bus_in  (bus_in),
        .q       (q),
        .bus_out (bus_out),
        .bus_oe  (bus_oe),
        .tc      (tc),
        .wrapped (wrapped)
    );

    // Rising edges at t = 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic applyStimulus(input logic vInc, input logic vLoad,
                                 input logic vOe, input logic [7:0] vBus);
        inc    = vInc;
        load   = vLoad;
        oe     = vOe;
        bus_in = vBus;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] observed,
                               input logic [7:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
        #2;
        checkOutput("rst_q", q, 8'h00);
        checkOutput("rst_wrapped", {7'b0, wrapped}, 8'h00);
        checkOutput("rst_bus_oe", {7'b0, bus_oe}, 8'h00);
        checkOutput("rst_bus_out", bus_out, 8'h00);
        checkOutput("rst_tc", {7'b0, tc}, 8'h00);
        #3;
        rst = 1'b0;
        #1;
        checkOutput("release_q", q, 8'h00);

        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
        tick();
        checkOutput("count1", q, 8'h01);
        tick();
        checkOutput("count2", q, 8'h02);

        // Nibble carry
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h0E);
        tick();
        checkOutput("load_0E", q, 8'h0E);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
        checkOutput("tc_at_0E", {7'b0, tc}, 8'h00);
        tick();
        checkOutput("inc_0F", q, 8'h0F);
        tick();
        checkOutput("carry_10", q, 8'h10);
        tick();
        checkOutput("inc_11", q, 8'h11);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
        tick();
        tick();
        tick();
        checkOutput("hold_11", q, 8'h11);

        // Wrap-around
        applyStimulus(1'b0, 1'b1, 1'b0, 8'hFE);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
        tick();
        checkOutput("wrap_q_FF", q, 8'hFF);
        checkOutput("wrap_tc_hi", {7'b0, tc}, 8'h01);
        checkOutput("wrap_flag_pre", {7'b0, wrapped}, 8'h00);
        tick();
        checkOutput("wrap_q_00", q, 8'h00);
        checkOutput("wrap_tc_lo", {7'b0, tc}, 8'h00);
        checkOutput("wrap_flag_set", {7'b0, wrapped}, 8'h01);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
        tick();
        checkOutput("wrap_flag_sticky", {7'b0, wrapped}, 8'h01);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h10);
        tick();
        checkOutput("wrap_clr_q", q, 8'h10);
        checkOutput("wrap_flag_clr", {7'b0, wrapped}, 8'h00);

        // Load beats increment at all-ones
        applyStimulus(1'b0, 1'b1, 1'b0, 8'hFF);
        tick();
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h42);
        checkOutput("prio_tc", {7'b0, tc}, 8'h00);
        tick();
        checkOutput("prio_q", q, 8'h42);
        checkOutput("prio_wrapped", {7'b0, wrapped}, 8'h00);

        // Registered output enable
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
        checkOutput("oe_same_cycle", bus_out, 8'h00);
        tick();
        checkOutput("oe_bus_oe", {7'b0, bus_oe}, 8'h01);
        checkOutput("oe_driven", bus_out, 8'h42);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
        checkOutput("oe_drop_same", bus_out, 8'h42);
        tick();
        checkOutput("oe_dropped", bus_out, 8'h00);

        // oe together with load
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
        tick();
        applyStimulus(1'b0, 1'b1, 1'b1, 8'h55);
        checkOutput("oe_load_pre", bus_out, 8'h42);
        tick();
        checkOutput("oe_load_post", bus_out, 8'h55);

        // Async reset mid-count, with a pending load discarded
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h37);
        tick();
        checkOutput("pre_reset_q", q, 8'h37);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'hAA);
        #3;
        rst = 1'b1;
        #1;
        checkOutput("async_rst_q", q, 8'h00);
        checkOutput("async_rst_bus_oe", {7'b0, bus_oe}, 8'h00);
        tick();
        tick();
        tick();
        tick();
        checkOutput("rst_hold_q", q, 8'h00);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
        #3;
        rst = 1'b0;
        tick();
        checkOutput("post_rst_q", q, 8'h00);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
        tick();
        checkOutput("post_rst_count", q, 8'h01);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
